// File: rtl/prbs31_checker.sv
// -----------------------------------------------------------------------------
// prbs31_checker
//
// Receive-side checker for a PRBS31 stream (x^31 + x^28 + 1). The checker
// first loads its LFSR directly from SEED_LEN received bits. It then predicts
// every following bit and counts the bits that do not match. Lock status is
// tracked over fixed windows of WINDOW valid bits. If ERR_THRESH errors land
// inside one window, the checker drops back to seeding.
//
// Ports:
//   CLK           in   1      rising-edge clock
//   RSTN          in   1      asynchronous active-low reset
//   bit_in        in   1      received PRBS bit, sampled only when bit_valid=1
//   bit_valid     in   1      qualifies bit_in for one cycle
//   clear_counts  in   1      synchronous clear of error_count / bit_count
//   locked        out  1      high while the checker is in CHECK
//   error_pulse   out  1      one-cycle pulse per mismatched bit
//   error_count   out  CNT_W  saturating count of mismatches
//   bit_count     out  CNT_W  saturating count of bits checked in CHECK
// -----------------------------------------------------------------------------
module prbs31_checker #(
  parameter int SEED_LEN   = 31,
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_counts,
  output logic             locked,
  output logic             error_pulse,
  output logic [CNT_W-1:0] error_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int LFSR_LEN = 31;
  localparam int SC_W     = $clog2(SEED_LEN + 1);
  localparam int WB_W     = $clog2(WINDOW + 1);
  localparam int WE_W     = $clog2(ERR_THRESH + 1);

  localparam logic [SC_W-1:0]  SEED_LAST = SC_W'(SEED_LEN - 1);
  localparam logic [WB_W-1:0]  WIN_FULL  = WB_W'(WINDOW);
  localparam logic [WE_W-1:0]  THRESH    = WE_W'(ERR_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_SEED  = 1'b0,
    ST_CHECK = 1'b1
  } state_e;

  // Saturating increment shared by both event counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  state_e              state_q,       state_d;
  logic [LFSR_LEN-1:0] lfsr_q,        lfsr_d;
  logic [SC_W-1:0]     seed_cnt_q,    seed_cnt_d;
  logic [WB_W-1:0]     win_bits_q,    win_bits_d;
  logic [WE_W-1:0]     win_errs_q,    win_errs_d;
  logic [CNT_W-1:0]    error_count_q, error_count_d;
  logic [CNT_W-1:0]    bit_count_q,   bit_count_d;
  logic                locked_q,      locked_d;
  logic                error_pulse_q, error_pulse_d;

  logic                exp_bit_s;
  logic                mismatch_s;
  logic [WB_W-1:0]     win_bits_inc_s;
  logic [WE_W-1:0]     win_errs_inc_s;

  // Next-state logic: seeding, prediction, window tracking and counters.
  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    seed_cnt_d     = seed_cnt_q;
    win_bits_d     = win_bits_q;
    win_errs_d     = win_errs_q;
    error_count_d  = error_count_q;
    bit_count_d    = bit_count_q;
    error_pulse_d  = 1'b0;
    exp_bit_s      = lfsr_q[30] ^ lfsr_q[27];
    mismatch_s     = 1'b0;
    win_bits_inc_s = win_bits_q + WB_W'(1);
    win_errs_inc_s = win_errs_q;

    case (state_q)
      ST_SEED: begin
        if (bit_valid) begin
          lfsr_d = {lfsr_q[29:0], bit_in};
          if (seed_cnt_q == SEED_LAST) begin
            seed_cnt_d = '0;
            // An all-zero seed is the LFSR lock-up state. It usually means
            // the line is stuck low, so seeding starts over.
            if (lfsr_d != '0) begin
              state_d = ST_CHECK;
            end else begin
              state_d = ST_SEED;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + SC_W'(1);
          end
        end else begin
          state_d = ST_SEED;
        end
      end

      ST_CHECK: begin
        if (bit_valid) begin
          mismatch_s     = bit_in ^ exp_bit_s;
          win_errs_inc_s = win_errs_q + WE_W'(mismatch_s);
          // The prediction is fed back instead of the received bit. A single
          // line error therefore costs exactly one mismatch and does not
          // spread into the following taps.
          lfsr_d         = {lfsr_q[29:0], exp_bit_s};
          bit_count_d    = sat_inc(bit_count_q);
          if (mismatch_s) begin
            error_pulse_d = 1'b1;
            error_count_d = sat_inc(error_count_q);
          end else begin
            error_pulse_d = 1'b0;
          end
          // Loss of lock is checked before window rollover, so it wins when
          // both happen on the same bit.
          if (mismatch_s && (win_errs_inc_s == THRESH)) begin
            state_d    = ST_SEED;
            seed_cnt_d = '0;
            win_bits_d = '0;
            win_errs_d = '0;
          end else if (win_bits_inc_s == WIN_FULL) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits_inc_s;
            win_errs_d = win_errs_inc_s;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end

      default: begin
        state_d    = ST_SEED;
        seed_cnt_d = '0;
        win_bits_d = '0;
        win_errs_d = '0;
      end
    endcase

    // A clear on the same cycle as an increment wins, so that bit is not
    // counted. error_pulse and the window tracking are left untouched.
    if (clear_counts) begin
      error_count_d = '0;
      bit_count_d   = '0;
    end else begin
      error_count_d = error_count_d;
      bit_count_d   = bit_count_d;
    end

    locked_d = (state_d == ST_CHECK);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= ST_SEED;
      lfsr_q        <= '0;
      seed_cnt_q    <= '0;
      win_bits_q    <= '0;
      win_errs_q    <= '0;
      error_count_q <= '0;
      bit_count_q   <= '0;
      locked_q      <= 1'b0;
      error_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      seed_cnt_q    <= seed_cnt_d;
      win_bits_q    <= win_bits_d;
      win_errs_q    <= win_errs_d;
      error_count_q <= error_count_d;
      bit_count_q   <= bit_count_d;
      locked_q      <= locked_d;
      error_pulse_q <= error_pulse_d;
    end
  end

  assign locked      = locked_q;
  assign error_pulse = error_pulse_q;
  assign error_count = error_count_q;
  assign bit_count   = bit_count_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs31_checker
//
// Drives two checker instances from the same stimulus: one with default
// parameters and one with 4-bit counters. Expected outputs come from a
// queue-based reference model of the checking rules.
// -----------------------------------------------------------------------------
module tb_prbs31_checker;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        clear_counts = 1'b0;

  logic        locked, error_pulse;
  logic [15:0] error_count, bit_count;
  logic        locked4, error_pulse4;
  logic [3:0]  error_count4, bit_count4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  prbs31_checker dut (
    .CLK(CLK), .RSTN(RSTN), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear_counts(clear_counts), .locked(locked), .error_pulse(error_pulse),
    .error_count(error_count), .bit_count(bit_count)
  );

  prbs31_checker #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RSTN(RSTN), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear_counts(clear_counts), .locked(locked4), .error_pulse(error_pulse4),
    .error_count(error_count4), .bit_count(bit_count4)
  );

  // Reference model state. m_hist holds the last 31 sequence bits, oldest
  // first. A bit n of the sequence is b[n-31] ^ b[n-28].
  bit m_seeding;
  bit m_hist[$];
  int m_wb, m_we, m_err, m_bits;
  bit m_pulse;
  bit gen_q[$];

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("locked",       32'(locked),       32'(!m_seeding));
    chk("error_pulse",  32'(error_pulse),  32'(m_pulse));
    chk("error_count",  32'(error_count),  sat(m_err, 65535));
    chk("bit_count",    32'(bit_count),    sat(m_bits, 65535));
    chk("locked4",      32'(locked4),      32'(!m_seeding));
    chk("error_pulse4", 32'(error_pulse4), 32'(m_pulse));
    chk("error_count4", 32'(error_count4), sat(m_err, 15));
    chk("bit_count4",   32'(bit_count4),   sat(m_bits, 15));
  endtask

  task automatic gen_seed(input int unsigned s);
    gen_q.delete();
    for (int i = 30; i >= 0; i--) gen_q.push_back(s[i]);
  endtask

  task automatic gen_next(output bit b);
    b = gen_q[0];
    gen_q.push_back(gen_q[0] ^ gen_q[3]);
    void'(gen_q.pop_front());
  endtask

  task automatic model_reset();
    m_seeding = 1'b1;
    m_hist.delete();
    m_wb = 0; m_we = 0; m_err = 0; m_bits = 0;
    m_pulse = 1'b0;
  endtask

  task automatic model_step(input bit b, input bit v, input bit c);
    bit nz;
    bit e;
    m_pulse = 1'b0;
    if (v) begin
      if (m_seeding) begin
        m_hist.push_back(b);
        if (m_hist.size() == 31) begin
          nz = 1'b0;
          foreach (m_hist[i]) nz |= m_hist[i];
          if (nz) m_seeding = 1'b0;
          else m_hist.delete();
        end
      end else begin
        e = m_hist[0] ^ m_hist[3];
        m_hist.push_back(e);
        void'(m_hist.pop_front());
        m_bits++;
        m_wb++;
        if (b != e) begin
          m_pulse = 1'b1;
          m_err++;
          m_we++;
        end
        if (b != e && m_we == 8) begin
          m_seeding = 1'b1;
          m_hist.delete();
          m_wb = 0; m_we = 0;
        end else if (m_wb == 64) begin
          m_wb = 0; m_we = 0;
        end
      end
    end
    if (c) begin
      m_err = 0;
      m_bits = 0;
    end
  endtask

  task automatic step(input bit b, input bit v, input bit c);
    bit_in = b; bit_valid = v; clear_counts = c;
    @(posedge CLK);
    #1;
    model_step(b, v, c);
    check_all();
  endtask

  task automatic send(input bit inv, input bit c);
    bit g;
    gen_next(g);
    step(g ^ inv, 1'b1, c);
  endtask

  task automatic gap();
    step(1'($urandom), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RSTN = 1'b0; bit_valid = 1'b0; clear_counts = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    #1;
    check_all();
    RSTN = 1'b1;
  endtask

  task automatic align();
    int guard = 0;
    while (m_wb != 0 && guard < 200) begin
      send(1'b0, 1'b0);
      guard++;
    end
  endtask

  task automatic pick_mask(input int n, output bit [63:0] mask);
    int cnt = 0;
    int p;
    mask = '0;
    while (cnt < n) begin
      p = $urandom_range(63);
      if (!mask[p]) begin
        mask[p] = 1'b1;
        cnt++;
      end
    end
  endtask

  initial begin
    bit [63:0] mask;
    int nerr;
    bit all_lk;
    int p;

    #2;
    gen_seed(32'd25);
    do_reset();

    // Clean lock and 1000 clean bits.
    for (int i = 0; i < 30; i++) send(1'b0, 1'b0);
    chk("not_locked_at_30", 32'(locked), 32'd0);
    send(1'b0, 1'b0);
    chk("locked_after_31", 32'(locked), 32'd1);
    for (int i = 0; i < 1000; i++) send(1'b0, 1'b0);
    chk("clean_bit_count", 32'(bit_count), 32'd1000);
    chk("clean_err_count", 32'(error_count), 32'd0);

    // Single error.
    for (int i = 0; i < 99; i++) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    chk("single_pulse", 32'(error_pulse), 32'd1);
    chk("single_count", 32'(error_count), 32'd1);
    chk("single_locked", 32'(locked), 32'd1);
    send(1'b0, 1'b0);
    chk("single_pulse_end", 32'(error_pulse), 32'd0);

    // Loss of lock: 8 errors inside one window.
    step(1'b0, 1'b0, 1'b1);
    align();
    pick_mask(8, mask);
    nerr = 0;
    for (int i = 0; i < 64; i++) begin
      send(mask[i], 1'b0);
      if (mask[i]) nerr++;
      if (nerr == 8) begin
        chk("lol_unlocked", 32'(locked), 32'd0);
        chk("lol_err_count", 32'(error_count), 32'd8);
        break;
      end
    end
    for (int i = 0; i < 30; i++) send(1'b0, 1'b0);
    chk("relock_pending", 32'(locked), 32'd0);
    send(1'b0, 1'b0);
    chk("relocked", 32'(locked), 32'd1);

    // Window rollover: 7 errors in each of 5 windows.
    step(1'b0, 1'b0, 1'b1);
    align();
    all_lk = 1'b1;
    for (int w = 0; w < 5; w++) begin
      pick_mask(7, mask);
      for (int i = 0; i < 64; i++) begin
        send(mask[i], 1'b0);
        if (locked !== 1'b1) all_lk = 1'b0;
      end
    end
    chk("rollover_locked", 32'(all_lk), 32'd1);
    chk("rollover_errs", 32'(error_count), 32'd35);

    // Stuck-low input with gaps, then reset mid-seed.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    chk("stuck_unlocked", 32'(locked), 32'd0);
    chk("stuck_bit_count", 32'(bit_count), 32'd0);
    gen_seed($urandom_range(32'h7FFF_FFFF, 32'd1));
    for (int i = 0; i < 15; i++) send(1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 30; i++) send(1'b0, 1'b0);
    chk("midseed_pending", 32'(locked), 32'd0);
    send(1'b0, 1'b0);
    chk("midseed_locked", 32'(locked), 32'd1);

    // Saturation: one error per window with random gaps, then clear + error.
    step(1'b0, 1'b0, 1'b1);
    for (int w = 0; w < 20; w++) begin
      p = $urandom_range(63);
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(3) == 0) gap();
        send(i == p, 1'b0);
      end
    end
    chk("sat_err4", 32'(error_count4), 32'd15);
    chk("sat_err16", 32'(error_count), 32'd20);
    chk("sat_bits16", 32'(bit_count), 32'd1280);
    chk("sat_bits4", 32'(bit_count4), 32'd15);
    send(1'b1, 1'b1);
    chk("clr_err16", 32'(error_count), 32'd0);
    chk("clr_err4", 32'(error_count4), 32'd0);
    chk("clr_bits16", 32'(bit_count), 32'd0);
    chk("clr_pulse", 32'(error_pulse), 32'd1);
    chk("clr_locked", 32'(locked), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
